l1_fill_biu: RTL and testbench

- Bus interface unit serving the L1 instruction/data cache controller on the memory side of its request interface.
- Accepts level requests from the cache: line refill, single read, or single write-through.
- Runs byte-wide transactions on the external memory bus and returns line bytes with a write strobe and byte counter.
- Signals completion or bus error back to the cache. Only one request is outstanding at a time.

---
 rtl/l1_fill_biu.sv | 255 +++++++++++++++++++++++++
 tb/tb_l1_fill_biu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_fill_biu.sv
// l1_fill_biu: memory-side bus interface unit for the L1 cache controller.
// Serves one request at a time: full line refill, single byte read, or
// single byte write-through, as byte-wide beats on the external bus.
// Optional build macro: BIU_TIMEOUT_EN adds a watchdog on mem_ack that
// turns a stalled beat into a bus error after TIMEOUT cycles.
module l1_fill_biu #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned LINE_BYTES = 256,
    parameter int unsigned LINE_WID   = $clog2(LINE_BYTES) - 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_line_req,
    input  logic                  read_req,
    input  logic                  write_through_req,
    input  logic [ADDR_WIDTH-1:0] pa,
    input  logic [7:0]            wt_data,
    output logic [7:0]            line_data,
    output logic [LINE_WID:0]     addr_count,
    output logic                  line_write,
    output logic                  cache_entry_refill,
    output logic                  trans_rdy,
    output logic                  bus_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,
    input  logic                  mem_err
);

    localparam int unsigned CW = LINE_WID + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINE_RD,
        S_SGL_RD,
        S_SGL_WR,
        S_DONE,
        S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic [7:0]            line_data_q, line_data_d;
    logic [CW-1:0]         addr_count_q, addr_count_d;
    logic                  line_write_q, line_write_d;
    logic                  refill_q, refill_d;
    logic                  trans_rdy_q, trans_rdy_d;
    logic                  bus_error_q, bus_error_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;

    logic                  strobe_c;
    logic                  timeout_c;
    logic                  fail_c;

    assign strobe_c = mem_rd_q | mem_wr_q;
    // Error beats mem_ack when both arrive in the same cycle.
    assign fail_c   = strobe_c & (mem_err | timeout_c);

`ifdef BIU_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wdog_q, wdog_d;

    // Fires on the last unacknowledged cycle so bus_error lands TIMEOUT cycles after the strobe rose.
    assign timeout_c = strobe_c & ~mem_ack & (wdog_q == WDW'(TIMEOUT - 1));

    // Watchdog counts strobe cycles without ack; any ack, idle bus or expiry clears it.
    always_comb begin
        wdog_d = '0;
        if (strobe_c && !mem_ack && !timeout_c) begin
            wdog_d = wdog_q + WDW'(1);
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_timeout;
    assign timeout_c      = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        line_data_d  = line_data_q;
        addr_count_d = addr_count_q;
        line_write_d = 1'b0;
        refill_d     = 1'b0;
        trans_rdy_d  = 1'b0;
        bus_error_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;

        unique case (state_q)
            S_IDLE: begin
                if (read_line_req) begin
                    base_d     = {pa[ADDR_WIDTH-1:CW], CW'(0)};
                    cnt_d      = '0;
                    last_d     = 1'b0;
                    mem_addr_d = {pa[ADDR_WIDTH-1:CW], CW'(0)};
                    mem_rd_d   = 1'b1;
                    state_d    = S_LINE_RD;
                end else if (read_req) begin
                    mem_addr_d = pa;
                    mem_rd_d   = 1'b1;
                    state_d    = S_SGL_RD;
                end else if (write_through_req) begin
                    mem_addr_d  = pa;
                    mem_wdata_d = wt_data;
                    mem_wr_d    = 1'b1;
                    state_d     = S_SGL_WR;
                end
            end

            S_LINE_RD: begin
                if (mem_rd_q) begin
                    if (fail_c) begin
                        mem_rd_d    = 1'b0;
                        bus_error_d = 1'b1;
                        state_d     = S_ERR;
                    end else if (mem_ack) begin
                        mem_rd_d     = 1'b0;
                        line_data_d  = mem_rdata;
                        addr_count_d = cnt_q;
                        line_write_d = 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            last_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end else begin
                    // Gap cycle between beats: abort, finish the line, or start the next beat.
                    if (!read_line_req) begin
                        state_d = S_IDLE;
                    end else if (last_q) begin
                        refill_d    = 1'b1;
                        trans_rdy_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        mem_addr_d = {base_q[ADDR_WIDTH-1:CW], cnt_q};
                        mem_rd_d   = 1'b1;
                    end
                end
            end

            S_SGL_RD: begin
                if (fail_c) begin
                    mem_rd_d    = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = S_ERR;
                end else if (mem_ack) begin
                    mem_rd_d    = 1'b0;
                    line_data_d = mem_rdata;
                    if (read_req) begin
                        trans_rdy_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_SGL_WR: begin
                if (fail_c) begin
                    mem_wr_d    = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = S_ERR;
                end else if (mem_ack) begin
                    mem_wr_d = 1'b0;
                    if (write_through_req) begin
                        trans_rdy_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DONE: state_d = S_IDLE;

            S_ERR: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears every output and strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            line_data_q  <= '0;
            addr_count_q <= '0;
            line_write_q <= 1'b0;
            refill_q     <= 1'b0;
            trans_rdy_q  <= 1'b0;
            bus_error_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            line_data_q  <= line_data_d;
            addr_count_q <= addr_count_d;
            line_write_q <= line_write_d;
            refill_q     <= refill_d;
            trans_rdy_q  <= trans_rdy_d;
            bus_error_q  <= bus_error_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign line_data          = line_data_q;
    assign addr_count         = addr_count_q;
    assign line_write         = line_write_q;
    assign cache_entry_refill = refill_q;
    assign trans_rdy          = trans_rdy_q;
    assign bus_error          = bus_error_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign mem_rd             = mem_rd_q;
    assign mem_wr             = mem_wr_q;

endmodule

// File: tb/tb_l1_fill_biu.sv
// Self-checking bench for l1_fill_biu: per-cycle vector table for single
// reads/writes, plus hand-written line refill, error, reset and watchdog runs.
module tb_l1_fill_biu;

    localparam int TB_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_line_req, read_req, write_through_req;
    logic [23:0] pa;
    logic [7:0]  wt_data;
    logic [7:0]  line_data;
    logic [7:0]  addr_count;
    logic        line_write, cache_entry_refill, trans_rdy, bus_error;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_rdata;
    logic        mem_ack, mem_err;

    int total = 0;
    int bad   = 0;

    l1_fill_biu #(
        .ADDR_WIDTH(24),
        .LINE_BYTES(256),
        .LINE_WID  (7),
        .TIMEOUT   (255)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .read_line_req     (read_line_req),
        .read_req          (read_req),
        .write_through_req (write_through_req),
        .pa                (pa),
        .wt_data           (wt_data),
        .line_data         (line_data),
        .addr_count        (addr_count),
        .line_write        (line_write),
        .cache_entry_refill(cache_entry_refill),
        .trans_rdy         (trans_rdy),
        .bus_error         (bus_error),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rd            (mem_rd),
        .mem_wr            (mem_wr),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .mem_err           (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lr, rr, wr;
        logic [23:0] pa;
        logic [7:0]  wd;
        logic        ack, err;
        logic [7:0]  rd;
        logic        e_mrd, e_mwr;
        logic [23:0] e_addr;
        logic [7:0]  e_wd, e_ld;
        logic        e_lw, e_tr, e_be, e_rf;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_line_data"},  32'(line_data), 32'd0);
        chk({tag, "_addr_count"}, 32'(addr_count), 32'd0);
        chk({tag, "_line_write"}, 32'(line_write), 32'd0);
        chk({tag, "_refill"},     32'(cache_entry_refill), 32'd0);
        chk({tag, "_trans_rdy"},  32'(trans_rdy), 32'd0);
        chk({tag, "_bus_error"},  32'(bus_error), 32'd0);
        chk({tag, "_mem_addr"},   32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"},  32'(mem_wdata), 32'd0);
        chk({tag, "_mem_rd"},     32'(mem_rd), 32'd0);
        chk({tag, "_mem_wr"},     32'(mem_wr), 32'd0);
    endtask

    // Line refill with a 1-cycle-ack memory returning addr[7:0]; optional error or reset beat.
    task automatic line_refill(input string tag, input logic [23:0] a, input logic with_rd,
                               input int err_beat, input int rst_beat,
                               input int exp_writes, input int exp_refills, input int exp_errs);
        logic [23:0] base;
        int beats, writes, refills, errs, last_wr, rf_cyc, cyc, addr_bad, beat_bad;
        bit stop;
        base = {a[23:8], 8'h00};
        beats = 0; writes = 0; refills = 0; errs = 0; last_wr = -10; rf_cyc = -20;
        cyc = 0; addr_bad = 0; beat_bad = 0; stop = 1'b0;
        read_line_req = 1'b1; read_req = with_rd; pa = a;
        while (!stop && cyc < 2000) begin
            step();
            cyc++;
            mem_ack = 1'b0;
            mem_err = 1'b0;
            if (line_write) begin
                if (addr_count !== line_data || addr_count !== 8'(writes)) beat_bad++;
                writes++;
                last_wr = cyc;
            end
            if (cache_entry_refill) begin
                refills++;
                rf_cyc = cyc;
                if (trans_rdy !== 1'b1) beat_bad++;
            end
            if (bus_error) errs++;
            if (trans_rdy || bus_error) begin
                read_line_req = 1'b0;
                read_req = 1'b0;
                stop = 1'b1;
            end else if (mem_rd) begin
                if (mem_addr !== base + 24'(beats)) addr_bad++;
                if (beats == rst_beat) begin
                    rst = 1'b1;
                    step();
                    cyc++;
                    chk_zero({tag, "_rst"});
                    rst = 1'b0;
                    read_line_req = 1'b0;
                    read_req = 1'b0;
                    stop = 1'b1;
                end else begin
                    mem_ack = 1'b1;
                    mem_err = (beats == err_beat);
                    mem_rdata = mem_addr[7:0];
                end
                beats++;
            end
        end
        mem_ack = 1'b0;
        mem_err = 1'b0;
        chk({tag, "_finished"}, 32'(stop), 32'd1);
        step();
        chk({tag, "_idle_rd"},     32'(mem_rd), 32'd0);
        chk({tag, "_idle_tr"},     32'(trans_rdy), 32'd0);
        chk({tag, "_idle_be"},     32'(bus_error), 32'd0);
        chk({tag, "_writes"},      32'(writes), 32'(exp_writes));
        chk({tag, "_refills"},     32'(refills), 32'(exp_refills));
        chk({tag, "_errors"},      32'(errs), 32'(exp_errs));
        chk({tag, "_addr_order"},  32'(addr_bad), 32'd0);
        chk({tag, "_beat_data"},   32'(beat_bad), 32'd0);
        if (exp_refills > 0) chk({tag, "_refill_after_last"}, 32'(rf_cyc), 32'(last_wr + 1));
    endtask

    initial begin
        int first_err;
        int lw_seen;
        bit got;

        //               lr    rr    wr    pa          wd     ack   err   rd     mrd   mwr   addr        ewd    eld    lw    tr    be    rf
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 24'h000010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000010, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 24'h000010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000010, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 24'h000010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000010, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 24'h000010, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 24'h000010, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 24'h000010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000010, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000010, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 24'h7FFFFE, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 24'h7FFFFE, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 24'h7FFFFE, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 24'h7FFFFE, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 24'h7FFFFE, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'h7FFFFE, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 24'h000123, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 24'h000123, 8'h55, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 24'h000123, 8'h55, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 24'h000123, 8'h55, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000123, 8'h55, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 24'h000055, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000055, 8'h55, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 24'h000055, 8'h00, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 24'h000055, 8'h55, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000055, 8'h55, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        read_line_req = 1'b0; read_req = 1'b0; write_through_req = 1'b0;
        pa = '0; wt_data = '0; mem_rdata = '0; mem_ack = 1'b0; mem_err = 1'b0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        step();
        chk_zero("post_reset");

        // Single read with 3-cycle ack, write-through, write error (err wins over ack), aborted read.
        for (int i = 0; i < NV; i++) begin
            read_line_req     = vecs[i].lr;
            read_req          = vecs[i].rr;
            write_through_req = vecs[i].wr;
            pa                = vecs[i].pa;
            wt_data           = vecs[i].wd;
            mem_ack           = vecs[i].ack;
            mem_err           = vecs[i].err;
            mem_rdata         = vecs[i].rd;
            step();
            chk($sformatf("v%0d_mem_rd", i),    32'(mem_rd), 32'(vecs[i].e_mrd));
            chk($sformatf("v%0d_mem_wr", i),    32'(mem_wr), 32'(vecs[i].e_mwr));
            chk($sformatf("v%0d_mem_addr", i),  32'(mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wd));
            chk($sformatf("v%0d_line_data", i), 32'(line_data), 32'(vecs[i].e_ld));
            chk($sformatf("v%0d_line_write", i), 32'(line_write), 32'(vecs[i].e_lw));
            chk($sformatf("v%0d_trans_rdy", i), 32'(trans_rdy), 32'(vecs[i].e_tr));
            chk($sformatf("v%0d_bus_error", i), 32'(bus_error), 32'(vecs[i].e_be));
            chk($sformatf("v%0d_refill", i),    32'(cache_entry_refill), 32'(vecs[i].e_rf));
            chk($sformatf("v%0d_addr_count", i), 32'(addr_count), 32'd0);
        end
        mem_ack = 1'b0;
        mem_err = 1'b0;

        // Full refill, line-aligned from 0x012345.
        line_refill("line_full", 24'h012345, 1'b0, -1, -1, 256, 1, 0);
        // Line plus single read together: line wins; error (with ack) on beat 40.
        line_refill("line_err40", 24'h0456AB, 1'b1, 40, -1, 40, 0, 1);

        // Normal single read after the error.
        read_req = 1'b1; pa = 24'h000010;
        got = 1'b0; lw_seen = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            mem_ack = 1'b0;
            if (line_write) lw_seen++;
            if (trans_rdy) begin
                got = 1'b1;
                chk("post_err_rd_data", 32'(line_data), 32'h5A);
                read_req = 1'b0;
            end else if (mem_rd) begin
                chk("post_err_rd_addr", 32'(mem_addr), 32'h000010);
                mem_ack = 1'b1;
                mem_rdata = 8'h5A;
            end
        end
        mem_ack = 1'b0;
        chk("post_err_rd_done", 32'(got), 32'd1);
        chk("post_err_rd_no_lw", 32'(lw_seen), 32'd0);
        step();

        // Reset while beat 10 of a refill is outstanding.
        line_refill("line_rst10", 24'h00AB00, 1'b0, -1, 10, 10, 0, 0);

        // Memory never acknowledges.
        read_req = 1'b1; pa = 24'h000020;
        step();
        chk("wd_rd_rise", 32'(mem_rd), 32'd1);
        first_err = -1;
        for (int c = 1; c <= 1000 && first_err < 0; c++) begin
            step();
            if (bus_error) first_err = c;
        end
        read_req = 1'b0;
`ifdef BIU_TIMEOUT_EN
        chk("wd_timeout_cycle", 32'(first_err), 32'(TB_TIMEOUT));
        chk("wd_strobe_dropped", 32'(mem_rd), 32'd0);
        step();
        step();
        chk("wd_idle_rd", 32'(mem_rd), 32'd0);
`else
        chk("wd_no_timeout", 32'(first_err), 32'hFFFFFFFF);
        chk("wd_still_waiting", 32'(mem_rd), 32'd1);
        rst = 1'b1;
        step();
        chk_zero("wd_rst");
        rst = 1'b0;
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
